// File: rtl/wb_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter_pkg
//   Shared types for the two-master Wishbone RAM arbiter: grant-FSM state
//   encodings, master identifiers and a bundled Wishbone request struct used
//   to mux the granted master onto the RAM port.
// -----------------------------------------------------------------------------
package wb_ram_arbiter_pkg;

  // Grant FSM state encodings.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  // Master identifiers, used for the round-robin "last granted" memory.
  typedef enum logic {
    ARB_M_I = 1'b0,
    ARB_M_D = 1'b1
  } arb_master_e;

  // Master-to-slave half of a Wishbone bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
  } wb_req_t;

endpackage : wb_ram_arbiter_pkg

// File: rtl/wb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_watchdog
//   Bus watchdog for one granted Wishbone transfer. Counts cycles in which the
//   strobe is up and the slave has not acknowledged; when the count reaches
//   TIMEOUT-1 without an ack, err_o pulses for that single cycle and the count
//   restarts. TIMEOUT=0 disables the error output. CNT_W must satisfy
//   2**CNT_W > TIMEOUT.
//
// Ports
//   clk_i     in  1  clock
//   rst_i     in  1  asynchronous active-high reset
//   clr_i     in  1  clear the count (grant is changing)
//   run_i     in  1  granted master has cyc & stb up this cycle
//   ack_i     in  1  slave ack this cycle (wins over a simultaneous timeout)
//   err_o     out 1  timeout error to the granted master (one-cycle pulse)
//   expire_o  out 1  limit reached this cycle, independent of ack; used to
//                    suppress the slave strobe without a loop through ack
// -----------------------------------------------------------------------------
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  input  logic ack_i,
  output logic err_o,
  output logic expire_o
);

  localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(LIMIT));
  assign expire_o   = (TIMEOUT != 0) && run_i && w_at_limit;
  assign err_o      = expire_o && !ack_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator runs processes in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i || !run_i || ack_i || expire_o) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      // Saturate rather than wrap so a huge TIMEOUT can never alias to zero.
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : wb_watchdog

// File: rtl/wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter
//   Shares one single-port Wishbone RAM between the core's instruction (I) and
//   data (D) masters. A grant is held for the whole bus cycle (while the owner
//   keeps cyc high, even with stb low), ties from IDLE go to the master that
//   was not granted last, and a master releasing cyc hands the bus straight to
//   a waiting master without an IDLE cycle. A watchdog ends stalled transfers
//   with err.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   iwbs_*_i / dwbs_*_i        I / D master requests (addr, dat, sel, cyc, stb, we)
//   iwbs_*_o / dwbs_*_o        I / D master responses (dat, ack, err); zero
//                              unless that master holds the grant
//   wbm_*_o                    request to the RAM (granted master's inputs)
//   wbm_dat_i, wbm_ack_i       RAM response; ack may be combinational
// -----------------------------------------------------------------------------
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // I master
  input  logic [31:0] iwbs_addr_i,
  input  logic [31:0] iwbs_dat_i,
  input  logic [3:0]  iwbs_sel_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic        iwbs_we_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  // D master
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  // RAM
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  arb_state_e  r_state, w_next_state;
  arb_master_e r_last_gnt, w_next_last_gnt;

  wb_req_t w_req_i, w_req_d, w_req_g;
  logic    w_want_i, w_want_d;
  logic    w_wd_err, w_wd_expire;

  assign w_req_i = '{addr: iwbs_addr_i, dat: iwbs_dat_i, sel: iwbs_sel_i,
                     cyc: iwbs_cyc_i, stb: iwbs_stb_i, we: iwbs_we_i};
  assign w_req_d = '{addr: dwbs_addr_i, dat: dwbs_dat_i, sel: dwbs_sel_i,
                     cyc: dwbs_cyc_i, stb: dwbs_stb_i, we: dwbs_we_i};

  assign w_want_i = iwbs_cyc_i && iwbs_stb_i;
  assign w_want_d = dwbs_cyc_i && dwbs_stb_i;

  // Granted request, all-zero in IDLE. Kept outside the output process so the
  // watchdog inputs never depend on a block that also reads its outputs.
  assign w_req_g = (r_state == ARB_GNT_I) ? w_req_i :
                   (r_state == ARB_GNT_D) ? w_req_d : '0;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ARB_IDLE;
      r_last_gnt <= ARB_M_D;  // first tie after reset goes to I
    end else begin
      r_state    <= w_next_state;
      r_last_gnt <= w_next_last_gnt;
    end
  end

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state    = r_state;
    w_next_last_gnt = r_last_gnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_want_i && w_want_d) begin
          w_next_state = (r_last_gnt == ARB_M_D) ? ARB_GNT_I : ARB_GNT_D;
        end else if (w_want_i) begin
          w_next_state = ARB_GNT_I;
        end else if (w_want_d) begin
          w_next_state = ARB_GNT_D;
        end
      end
      ARB_GNT_I: begin
        if (!iwbs_cyc_i) begin
          w_next_last_gnt = ARB_M_I;
          w_next_state    = w_want_d ? ARB_GNT_D : ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (!dwbs_cyc_i) begin
          w_next_last_gnt = ARB_M_D;
          w_next_state    = w_want_i ? ARB_GNT_I : ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (r_state != w_next_state),
    .run_i    (w_req_g.cyc && w_req_g.stb),
    .ack_i    (wbm_ack_i),
    .err_o    (w_wd_err),
    .expire_o (w_wd_expire)
  );

  // Output logic: slave-side mux plus response routing to the grant owner.
  always_comb begin
    wbm_addr_o = w_req_g.addr;
    wbm_dat_o  = w_req_g.dat;
    wbm_sel_o  = w_req_g.sel;
    wbm_cyc_o  = w_req_g.cyc;
    wbm_we_o   = w_req_g.we;
    // The strobe is withdrawn in the timeout cycle so the RAM cannot complete
    // a transfer that the master is simultaneously told has failed.
    wbm_stb_o  = w_req_g.stb && !w_wd_expire;

    iwbs_dat_o = '0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_dat_o = '0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    case (r_state)
      ARB_GNT_I: begin
        iwbs_dat_o = wbm_dat_i;
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = w_wd_err;
      end
      ARB_GNT_D: begin
        dwbs_dat_o = wbm_dat_i;
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = w_wd_err;
      end
      default: ;
    endcase
  end

endmodule : wb_ram_arbiter

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Master-side stimulus, index 0 = I, 1 = D.
  logic        m_cyc[2], m_stb[2], m_we[2];
  logic [31:0] m_addr[2], m_wdat[2];
  logic [3:0]  m_sel[2];
  logic [31:0] m_rdat[2];
  logic        m_ack[2], m_err[2];

  logic [31:0] iwbs_dat_o, dwbs_dat_o, wbm_addr_o, wbm_dat_o, wbm_dat_i;
  logic        iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;

  assign m_rdat[0] = iwbs_dat_o;
  assign m_rdat[1] = dwbs_dat_o;
  assign m_ack[0]  = iwbs_ack_o;
  assign m_ack[1]  = dwbs_ack_o;
  assign m_err[0]  = iwbs_err_o;
  assign m_err[1]  = dwbs_err_o;

  wb_ram_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .iwbs_addr_i (m_addr[0]),
    .iwbs_dat_i  (m_wdat[0]),
    .iwbs_sel_i  (m_sel[0]),
    .iwbs_cyc_i  (m_cyc[0]),
    .iwbs_stb_i  (m_stb[0]),
    .iwbs_we_i   (m_we[0]),
    .iwbs_dat_o  (iwbs_dat_o),
    .iwbs_ack_o  (iwbs_ack_o),
    .iwbs_err_o  (iwbs_err_o),
    .dwbs_addr_i (m_addr[1]),
    .dwbs_dat_i  (m_wdat[1]),
    .dwbs_sel_i  (m_sel[1]),
    .dwbs_cyc_i  (m_cyc[1]),
    .dwbs_stb_i  (m_stb[1]),
    .dwbs_we_i   (m_we[1]),
    .dwbs_dat_o  (dwbs_dat_o),
    .dwbs_ack_o  (dwbs_ack_o),
    .dwbs_err_o  (dwbs_err_o),
    .wbm_addr_o  (wbm_addr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i)
  );

  // RAM model: combinational ack when ram_auto, otherwise ack = force_ack.
  logic [31:0] mem [256];
  logic        ram_auto, force_ack;

  assign wbm_ack_i = ram_auto ? (wbm_cyc_o && wbm_stb_o) : force_ack;
  assign wbm_dat_i = mem[wbm_addr_o[9:2]];

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wbm_sel_o[b]) mem[wbm_addr_o[9:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end
    end
  end

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
                               iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o}), 32'd0);
    check({tag, "_data"}, wbm_addr_o | wbm_dat_o | iwbs_dat_o | dwbs_dat_o, 32'd0);
  endtask

  // Scoreboard: one expected response per issued transfer, per master.
  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_i_q[$];
  exp_t exp_d_q[$];
  int   order_q[$];   // master index of each observed response, in order

  task automatic push_exp(input int m, input exp_t e);
    if (m == 0) exp_i_q.push_back(e);
    else        exp_d_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (m_ack[m] || m_err[m]) begin
          exp_t e;
          int   qs;
          order_q.push_back(m);
          check($sformatf("m%0d_ack_err_excl", m), 32'(m_ack[m] && m_err[m]), 32'd0);
          qs = (m == 0) ? exp_i_q.size() : exp_d_q.size();
          if (qs == 0) begin
            check($sformatf("m%0d_unexpected_resp", m), 32'd1, 32'd0);
          end else begin
            e = (m == 0) ? exp_i_q.pop_front() : exp_d_q.pop_front();
            check($sformatf("m%0d_resp_is_err", m), 32'(m_err[m]), 32'(e.is_err));
            if (e.chk_dat) check($sformatf("m%0d_rdata", m), m_rdat[m], e.dat);
          end
        end
      end
    end
  end

  // One Wishbone transfer. Call just after a rising edge; returns after the
  // edge that completes it, with lat = negedges waited until ack/err.
  task automatic bus_op(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [3:0] sel, input logic keep,
                        input logic exp_err, input logic [31:0] exp_dat, output int lat);
    push_exp(m, '{is_err: exp_err, chk_dat: !we && !exp_err, dat: exp_dat});
    m_cyc[m]  = 1'b1;
    m_stb[m]  = 1'b1;
    m_we[m]   = we;
    m_addr[m] = addr;
    m_wdat[m] = wdat;
    m_sel[m]  = sel;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (m_ack[m] || m_err[m]) break;
      if (lat >= 64) begin
        check($sformatf("m%0d_bus_timeout", m), 32'(lat), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    m_stb[m] = 1'b0;
    if (!keep) m_cyc[m] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int lat_i, lat_d, lat;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_addr[m] = '0;  m_wdat[m] = '0;  m_sel[m] = 4'hF;
    end
    ram_auto  = 1'b1;
    force_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[8'h40] = 32'hDEAD_BEEF;   // 0x100
    mem[8'h41] = 32'h0BAD_F00D;   // 0x104
    mem[8'h84] = 32'hFFFF_FFFF;   // 0x210

    // Reset state
    idle(3);
    check_all_zero("rst_init");
    rst = 1'b0;
    idle(1);

    // Single I read: granted after one arbitration cycle, data routed to I
    bus_op(0, 1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, lat_i);
    check("i_read_lat", 32'(lat_i), 32'd2);
    idle(2);

    // Reset while D holds a stalled transfer
    ram_auto  = 1'b0;
    m_cyc[1]  = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h300;
    repeat (3) @(negedge clk);
    check("d_gnt_cyc", 32'(wbm_cyc_o), 32'd1);
    check("d_gnt_addr", wbm_addr_o, 32'h300);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    ram_auto = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Tie from reset: I first, D handed the bus directly, RAM cyc stays granted
    order_q.delete();
    fork
      bus_op(0, 1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, lat_i);
      bus_op(1, 1'b0, 32'h104, '0, 4'hF, 1'b0, 1'b0, 32'h0BAD_F00D, lat_d);
      begin
        repeat (2) @(negedge clk);
        check("handoff_i_addr", wbm_addr_o, 32'h100);
        repeat (2) @(negedge clk);
        check("handoff_d_cyc", 32'(wbm_cyc_o), 32'd1);
        check("handoff_d_addr", wbm_addr_o, 32'h104);
      end
    join
    check("tie1_first", (order_q.size() > 0) ? 32'(order_q[0]) : 32'hFFFF, 32'd0);
    check("tie1_i_lat", 32'(lat_i), 32'd2);
    check("tie1_d_lat_no_idle", 32'(lat_d), 32'd4);
    idle(2);

    // After a lone I transfer, the next tie goes to D
    bus_op(0, 1'b0, 32'h104, '0, 4'hF, 1'b0, 1'b0, 32'h0BAD_F00D, lat_i);
    idle(1);
    order_q.delete();
    fork
      bus_op(0, 1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, lat_i);
      bus_op(1, 1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF, lat_d);
    join
    check("tie2_first", (order_q.size() > 0) ? 32'(order_q[0]) : 32'hFFFF, 32'd1);
    check("tie2_d_lat", 32'(lat_d), 32'd2);
    idle(2);

    // D locks the bus for a burst of writes while I waits
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          bus_op(1, 1'b1, 32'h200 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 4'hF, 1'b1,
                 1'b0, '0, lat);
        bus_op(1, 1'b1, 32'h210, 32'h1234_ABCD, 4'b0011, 1'b0, 1'b0, '0, lat);
      end
      begin
        idle(2);
        bus_op(0, 1'b0, 32'h104, '0, 4'hF, 1'b0, 1'b0, 32'h0BAD_F00D, lat_i);
      end
    join
    check("burst_resp_count", 32'(order_q.size()), 32'd6);
    check("burst_i_last", (order_q.size() == 6) ? 32'(order_q[5]) : 32'hFFFF, 32'd0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      bus_op(1, 1'b0, 32'h200 + 32'(4*i), '0, 4'hF, 1'b0, 1'b0, 32'h1111_1111 * 32'(i+1), lat);
      idle(1);
    end
    bus_op(1, 1'b0, 32'h210, '0, 4'hF, 1'b0, 1'b0, 32'hFFFF_ABCD, lat);
    idle(2);

    // Watchdog: RAM never acks -> one-cycle err after TIMEOUT granted cycles
    ram_auto  = 1'b0;
    force_ack = 1'b0;
    push_exp(1, '{is_err: 1'b1, chk_dat: 1'b0, dat: '0});
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h100;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (dwbs_err_o || lat >= 40) break;
    end
    // one arbitration cycle, then TIMEOUT stalled granted cycles
    check("wd_err_lat", 32'(lat), 32'(TIMEOUT + 1));
    check("wd_err_stb_low", 32'(wbm_stb_o), 32'd0);
    @(negedge clk);
    check("wd_err_one_cycle", 32'(dwbs_err_o), 32'd0);
    check("wd_stb_restored", 32'(wbm_stb_o), 32'd1);
    idle(1);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    idle(2);

    // Ack arriving in the last watchdog cycle wins over the timeout
    push_exp(1, '{is_err: 1'b0, chk_dat: 1'b1, dat: 32'hDEAD_BEEF});
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h100;
    idle(TIMEOUT);
    force_ack = 1'b1;
    @(negedge clk);
    check("wd_late_ack", 32'(dwbs_ack_o), 32'd1);
    check("wd_late_ack_no_err", 32'(dwbs_err_o), 32'd0);
    idle(1);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; force_ack = 1'b0; ram_auto = 1'b1;
    idle(3);

    check("sb_i_drained", 32'(exp_i_q.size()), 32'd0);
    check("sb_d_drained", 32'(exp_d_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wb_ram_arbiter
